// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes, and mux selects.
// Latency: n/a (types and constants only). Backpressure: none.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_LUI  = 3'd3;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JMP  = 2'd2;
    localparam logic [1:0] NPC_REG  = 2'd3;

    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;

    localparam logic [1:0] M2R_ALU  = 2'd0;
    localparam logic [1:0] M2R_DM   = 2'd1;
    localparam logic [1:0] M2R_PC   = 2'd2;

    // One-hot-ish instruction class flags; all zero means nop.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic jal;
    } dec_t;

    function automatic logic [2:0] alu_sel(input dec_t d);
        logic [2:0] sel;
        sel = ALU_ADD;
        if (d.subu || d.beq) sel = ALU_SUB;
        else if (d.ori)      sel = ALU_OR;
        else if (d.lui)      sel = ALU_LUI;
        return sel;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func to instruction-class flags.
// Latency: 0 cycles. Backpressure: none.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (op)
            OP_RTYPE: begin
                dec.addu = (func == FN_ADDU);
                dec.subu = (func == FN_SUBU);
                dec.jr   = (func == FN_JR);
            end
            OP_ORI: dec.ori = 1'b1;
            OP_LW:  dec.lw  = 1'b1;
            OP_SW:  dec.sw  = 1'b1;
            OP_BEQ: dec.beq = 1'b1;
            OP_LUI: dec.lui = 1'b1;
            OP_J:   dec.j   = 1'b1;
            OP_JAL: dec.jal = 1'b1;
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with retired-instruction counter.
// Latency: 2-5 cycles per instruction. Backpressure: none.
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             Zero,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       RegDst,
    output logic             ALUSrc,
    output logic [1:0]       MemToReg,
    output logic             ExtOp,
    output logic [2:0]       ALUCtrl,
    output logic [1:0]       NPCOp,
    output logic [2:0]       state,
    output logic             done,
    output logic [CNT_W-1:0] icnt
);

    state_t state_q;
    state_t state_nxt;
    dec_t   dec;

    logic pc_wr;
    logic ir_wr;
    logic reg_wr;
    logic mem_wr;
    logic fin;

    // IR only loads in FETCH, so op/func are stable for the rest of the instruction
    // and never reach the outputs while FETCH is active.
    mc_decode u_decode (
        .op   (op),
        .func (func),
        .dec  (dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            icnt    <= '0;
        end else begin
            state_q <= state_nxt;
            if (fin) begin
                icnt <= icnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = S_FETCH;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        mem_wr    = 1'b0;
        fin       = 1'b0;
        RegDst    = RD_RT;
        ALUSrc    = 1'b0;
        MemToReg  = M2R_ALU;
        ExtOp     = 1'b0;
        ALUCtrl   = ALU_ADD;
        NPCOp     = NPC_PC4;

        case (state_q)
            S_FETCH: begin
                ir_wr     = 1'b1;
                pc_wr     = 1'b1;
                NPCOp     = NPC_PC4;
                state_nxt = S_DCD;
            end
            S_DCD: begin
                if (dec.j || dec.jal) begin
                    pc_wr = 1'b1;
                    NPCOp = NPC_JMP;
                end
                if (dec.jr) begin
                    pc_wr = 1'b1;
                    NPCOp = NPC_REG;
                end
                if (dec.jal) begin
                    reg_wr   = 1'b1;
                    RegDst   = RD_RA;
                    MemToReg = M2R_PC;
                end
                // Jumps and unsupported encodings retire straight from decode.
                if (dec.addu || dec.subu || dec.ori || dec.lui ||
                    dec.lw || dec.sw || dec.beq) begin
                    state_nxt = S_EXE;
                end else begin
                    state_nxt = S_FETCH;
                    fin       = 1'b1;
                end
            end
            S_EXE: begin
                ALUSrc  = dec.ori || dec.lui || dec.lw || dec.sw;
                ExtOp   = dec.lw || dec.sw || dec.beq;
                ALUCtrl = alu_sel(dec);
                if (dec.beq) begin
                    pc_wr     = Zero;
                    NPCOp     = NPC_BR;
                    state_nxt = S_FETCH;
                    fin       = 1'b1;
                end else if (dec.lw || dec.sw) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (dec.sw) begin
                    mem_wr    = 1'b1;
                    state_nxt = S_FETCH;
                    fin       = 1'b1;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                reg_wr    = 1'b1;
                RegDst    = (dec.addu || dec.subu) ? RD_RD : RD_RT;
                MemToReg  = dec.lw ? M2R_DM : M2R_ALU;
                state_nxt = S_FETCH;
                fin       = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Reset gates the enables combinationally so nothing can fire while held.
    assign PCWr     = pc_wr  && reset;
    assign IRWr     = ir_wr  && reset;
    assign RegWrite = reg_wr && reset;
    assign MemWrite = mem_wr && reset;
    assign done     = fin    && reset;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller with a 4-bit retired-instruction counter.
module tb_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       PCWr, IRWr, RegWrite, MemWrite, ALUSrc, ExtOp, done;
    logic [1:0] RegDst, MemToReg, NPCOp;
    logic [2:0] ALUCtrl, state;
    logic [3:0] icnt;

    int         checks;
    int         errors;
    logic [3:0] exp_icnt;

    mc_controller #(.CNT_W(4)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .op       (op),
        .func     (func),
        .Zero     (zero),
        .PCWr     (PCWr),
        .IRWr     (IRWr),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .RegDst   (RegDst),
        .ALUSrc   (ALUSrc),
        .MemToReg (MemToReg),
        .ExtOp    (ExtOp),
        .ALUCtrl  (ALUCtrl),
        .NPCOp    (NPCOp),
        .state    (state),
        .done     (done),
        .icnt     (icnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input logic [2:0] st);
        @(negedge clk);
        chk("state", 32'(state), 32'(st));
    endtask

    task automatic retire();
        @(negedge clk);
        chk("retire_state", 32'(state), 32'd0);
        exp_icnt = exp_icnt + 4'd1;
        chk("icnt", 32'(icnt), 32'(exp_icnt));
        chk("done_fetch", 32'(done), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pcwr"}, 32'(PCWr), 32'd0);
        chk({tag, "_irwr"}, 32'(IRWr), 32'd0);
        chk({tag, "_regwr"}, 32'(RegWrite), 32'd0);
        chk({tag, "_memwr"}, 32'(MemWrite), 32'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_icnt = 4'd0;
        rst_n    = 1'b0;
        op       = 6'h23;
        func     = 6'h00;
        zero     = 1'b0;

        // Held in reset: FETCH but every enable masked.
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_icnt", 32'(icnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_quiet("rst");

        rst_n = 1'b1;
        #1;
        chk("rel_irwr", 32'(IRWr), 32'd1);
        chk("rel_pcwr", 32'(PCWr), 32'd1);
        chk("rel_npc", 32'(NPCOp), 32'd0);

        // lw: FETCH, DCD, EXE, MEM, WB
        tick(3'd1);
        chk("lw_dcd_regwr", 32'(RegWrite), 32'd0);
        chk("lw_dcd_done", 32'(done), 32'd0);
        tick(3'd2);
        chk("lw_exe_alusrc", 32'(ALUSrc), 32'd1);
        chk("lw_exe_ext", 32'(ExtOp), 32'd1);
        chk("lw_exe_alu", 32'(ALUCtrl), 32'd0);
        chk("lw_exe_regwr", 32'(RegWrite), 32'd0);
        tick(3'd3);
        chk("lw_mem_memwr", 32'(MemWrite), 32'd0);
        chk("lw_mem_regwr", 32'(RegWrite), 32'd0);
        chk("lw_mem_done", 32'(done), 32'd0);
        tick(3'd4);
        chk("lw_wb_regwr", 32'(RegWrite), 32'd1);
        chk("lw_wb_m2r", 32'(MemToReg), 32'd1);
        chk("lw_wb_rdst", 32'(RegDst), 32'd0);
        chk("lw_wb_done", 32'(done), 32'd1);
        chk("lw_wb_icnt", 32'(icnt), 32'd0);
        retire();

        // lw aborted by reset in EXE
        tick(3'd1);
        tick(3'd2);
        rst_n = 1'b0;
        #1;
        exp_icnt = 4'd0;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_icnt", 32'(icnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk_quiet("abort");
        @(negedge clk);
        chk("abort_hold_state", 32'(state), 32'd0);
        chk_quiet("abort_hold");
        rst_n = 1'b1;
        #1;
        chk("rel2_irwr", 32'(IRWr), 32'd1);

        // beq taken
        op   = 6'h04;
        zero = 1'b1;
        tick(3'd1);
        chk("beq1_dcd_pcwr", 32'(PCWr), 32'd0);
        tick(3'd2);
        chk("beq1_pcwr", 32'(PCWr), 32'd1);
        chk("beq1_npc", 32'(NPCOp), 32'd1);
        chk("beq1_alu", 32'(ALUCtrl), 32'd1);
        chk("beq1_ext", 32'(ExtOp), 32'd1);
        chk("beq1_done", 32'(done), 32'd1);
        retire();

        // beq not taken
        zero = 1'b0;
        tick(3'd1);
        tick(3'd2);
        chk("beq0_pcwr", 32'(PCWr), 32'd0);
        chk("beq0_done", 32'(done), 32'd1);
        chk("beq0_regwr", 32'(RegWrite), 32'd0);
        retire();

        // jal
        op = 6'h03;
        tick(3'd1);
        chk("jal_pcwr", 32'(PCWr), 32'd1);
        chk("jal_npc", 32'(NPCOp), 32'd2);
        chk("jal_regwr", 32'(RegWrite), 32'd1);
        chk("jal_rdst", 32'(RegDst), 32'd2);
        chk("jal_m2r", 32'(MemToReg), 32'd2);
        chk("jal_done", 32'(done), 32'd1);
        retire();

        // unsupported opcode behaves as nop
        op = 6'h3F;
        tick(3'd1);
        chk("nop_pcwr", 32'(PCWr), 32'd0);
        chk("nop_regwr", 32'(RegWrite), 32'd0);
        chk("nop_memwr", 32'(MemWrite), 32'd0);
        chk("nop_done", 32'(done), 32'd1);
        retire();

        // sw
        op = 6'h2B;
        tick(3'd1);
        tick(3'd2);
        chk("sw_alusrc", 32'(ALUSrc), 32'd1);
        chk("sw_ext", 32'(ExtOp), 32'd1);
        tick(3'd3);
        chk("sw_memwr", 32'(MemWrite), 32'd1);
        chk("sw_regwr", 32'(RegWrite), 32'd0);
        chk("sw_done", 32'(done), 32'd1);
        retire();

        // j
        op = 6'h02;
        tick(3'd1);
        chk("j_pcwr", 32'(PCWr), 32'd1);
        chk("j_npc", 32'(NPCOp), 32'd2);
        chk("j_regwr", 32'(RegWrite), 32'd0);
        retire();

        // jr
        op   = 6'h00;
        func = 6'h08;
        tick(3'd1);
        chk("jr_pcwr", 32'(PCWr), 32'd1);
        chk("jr_npc", 32'(NPCOp), 32'd3);
        retire();

        // ori: zero-extended immediate, OR
        op = 6'h0D;
        tick(3'd1);
        tick(3'd2);
        chk("ori_alu", 32'(ALUCtrl), 32'd2);
        chk("ori_alusrc", 32'(ALUSrc), 32'd1);
        chk("ori_ext", 32'(ExtOp), 32'd0);
        tick(3'd4);
        chk("ori_rdst", 32'(RegDst), 32'd0);
        chk("ori_m2r", 32'(MemToReg), 32'd0);
        retire();

        // subu
        op   = 6'h00;
        func = 6'h23;
        tick(3'd1);
        tick(3'd2);
        chk("subu_alu", 32'(ALUCtrl), 32'd1);
        chk("subu_alusrc", 32'(ALUSrc), 32'd0);
        tick(3'd4);
        chk("subu_rdst", 32'(RegDst), 32'd1);
        retire();

        // lui
        op = 6'h0F;
        tick(3'd1);
        tick(3'd2);
        chk("lui_alu", 32'(ALUCtrl), 32'd3);
        chk("lui_alusrc", 32'(ALUSrc), 32'd1);
        tick(3'd4);
        chk("lui_regwr", 32'(RegWrite), 32'd1);
        retire();

        // 16 addu: four cycles each, counter passes 15 -> 0
        op   = 6'h00;
        func = 6'h21;
        for (int k = 0; k < 16; k++) begin
            tick(3'd1);
            chk("addu_dcd_done", 32'(done), 32'd0);
            tick(3'd2);
            chk("addu_alu", 32'(ALUCtrl), 32'd0);
            chk("addu_alusrc", 32'(ALUSrc), 32'd0);
            tick(3'd4);
            chk("addu_regwr", 32'(RegWrite), 32'd1);
            chk("addu_rdst", 32'(RegDst), 32'd1);
            chk("addu_done", 32'(done), 32'd1);
            retire();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
